ucode_dispatch: RTL and testbench
=================================

UCODE_DISPATCH -- requirements
Module: ucode_dispatch

Interface
REQ-001 SHALL have parameter DEPTH_P, default 4, meaning queue entries; legal values are powers of 2 and at least 2.
REQ-002 SHALL have parameter NUM_FU_P, default 8, meaning width of fu_ready_i, indexed by FU code.
REQ-003 SHALL have port clk_i, input, width 1: the single clock.
REQ-004 SHALL have port reset_i, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have these upstream ports:
  - ucode_v_i, input, 1: FE word valid.
  - ucode_i, input, UCODE_WIDTH_P: packed microcode word {WE,OP,FU,FLAGS,DEST_SRC,S1_SRC,S2_SRC,IMM}, MSB first.
  - instr_i, input, 16: raw instruction.
  - pc_i, input, 16: instruction PC.
  - ucode_ready_o, output, 1: queue can accept.
REQ-006 SHALL have port flush_i, input, width 1: discard all queued entries.
REQ-007 SHALL have port fu_ready_i, input, width NUM_FU_P: per-FU accept.
REQ-008 SHALL have port branch_resolved_i, input, width 1: the outstanding branch has completed.
REQ-009 SHALL have these dispatch ports:
  - dispatch_v_o, output, 1.
  - dispatch_fu_o, output, FU_WIDTH_P.
  - dispatch_op_o, output, 3.
  - we_o, output, 1.
  - flags_o, output, 4.
  - dest_src_o, output, 2.
  - s1_src_o, output, 2.
  - s2_src_o, output, 4.
  - imm_o, output, 1.
  - instr_o, output, 16.
  - pc_o, output, 16.

Function
REQ-010 SHALL push the entry {ucode_i, instr_i, pc_i} at the tail when ucode_v_i && ucode_ready_o && !flush_i.
REQ-011 SHALL drive ucode_ready_o = (count != DEPTH_P) from registered state; a pop in the same cycle does not allow a push into a full queue.
REQ-012 SHALL have no bypass: an entry pushed in cycle N is first visible at the head in cycle N+1.
REQ-013 SHALL drive all dispatch field outputs combinationally from the unpacked head entry.
REQ-014 SHALL drive dispatch_v_o = head_valid && state==RUN && FU!=NOOP_FU && fu_ready_i[FU] && !flush_i.
REQ-015 SHALL pop the head when dispatch_v_o is 1, or when head_valid && state==RUN && FU==NOOP_FU && !flush_i; a NOOP pop raises no dispatch_v_o.
REQ-016 SHALL limit pops to one per cycle.
REQ-017 SHALL use FSM states RUN and WAIT_BR.
REQ-018 SHALL transition RUN->WAIT_BR on the cycle after a dispatch with FU==BRANCH_FU.
REQ-019 SHALL transition WAIT_BR->RUN on branch_resolved_i; branch_resolved_i is ignored in RUN.
REQ-020 SHALL perform no dispatch and no pop in WAIT_BR; pushes continue while not full.
REQ-021 On flush_i SHALL clear count and pointers, set state to RUN, and drop any same-cycle push.
REQ-022 On flush_i coinciding with branch_resolved_i, flush SHALL win, ending in RUN with an empty queue.
REQ-023 SHALL wrap head and tail pointers modulo DEPTH_P; count runs 0..DEPTH_P, never overflowing or underflowing.
REQ-024 SHALL allow simultaneous push and pop when not full and not empty, leaving count unchanged.
REQ-025 SHALL stall the head while fu_ready_i[FU]==0, holding all outputs stable.

Reset
REQ-026 reset_i SHALL, at the clock edge, set count=0, head=tail=0 and state=RUN.
REQ-027 During and after reset, ucode_ready_o SHALL be 1 and dispatch_v_o SHALL be 0.
REQ-028 Dispatch field outputs are don't-care while dispatch_v_o=0.
REQ-029 reset_i SHALL take priority over flush_i and push.
REQ-030 A reset mid-WAIT_BR SHALL return to RUN with an empty queue.
REQ-031 Queue storage SHALL need no reset.

Structure
REQ-032 UCODE_WIDTH_P, FU_WIDTH_P, the FU codes (NOOP_FU, ALU_FU, MUL_FU, DIV_FU, LOGICAL_FU, MEM_FU, BRANCH_FU), the OP codes, a packed ucode_s struct matching the field order, and the dispatch state enum SHALL live in Purple_Jade_pkg.
REQ-033 The queue SHALL be a sub-module, ucode_fifo (parameters width and DEPTH_P; ports v/ready in, v/yumi out, clear).
REQ-034 The FSM and unpack logic SHALL remain in ucode_dispatch.

Verification
REQ-035 Reset, then push ALU ADD (pc=0x0010) with fu_ready_i all 1 -> dispatch_v_o=1 in the next cycle, dispatch_fu_o=ALU_FU, pc_o=0x0010, count returns to 0.
REQ-036 Push 4 entries with fu_ready_i=0 -> ucode_ready_o=0 after the 4th; a 5th push is refused; raise fu_ready_i -> 4 dispatches on consecutive cycles in order, with ucode_ready_o=1 after the first pop.
REQ-037 Push NOOP, then MUL -> NOOP is popped silently in cycle 1 and MUL dispatches in cycle 2.
REQ-038 Push BCC, ALU -> BCC dispatches; ALU is held with dispatch_v_o=0 for 3 cycles until branch_resolved_i pulses, then ALU dispatches the next cycle.
REQ-039 In WAIT_BR with 3 entries queued, assert flush_i together with ucode_v_i and branch_resolved_i -> next cycle count=0, state RUN, the pushed word is lost, and dispatch_v_o=0.
REQ-040 Run 1000 random pushes, fu_ready_i values and flushes against a scoreboard model -> in-order, no duplicated and no lost entries between flushes, with pointer wrap exercised.

Source files
------------

// File: rtl/Purple_Jade_pkg.sv
// Shared types for the microcode dispatch queue:
// field widths, FU/OP codes, packed word layout, FSM states.
package Purple_Jade_pkg;

  localparam int FU_WIDTH_P    = 3;
  localparam int OP_WIDTH_P    = 3;
  localparam int UCODE_WIDTH_P = 20;
  localparam int ENTRY_WIDTH_P = UCODE_WIDTH_P + 32;

  typedef enum logic [FU_WIDTH_P-1:0] {
    NOOP_FU    = 3'd0,
    ALU_FU     = 3'd1,
    MUL_FU     = 3'd2,
    DIV_FU     = 3'd3,
    LOGICAL_FU = 3'd4,
    MEM_FU     = 3'd5,
    BRANCH_FU  = 3'd6
  } fu_e;

  typedef enum logic [OP_WIDTH_P-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  // {WE,OP,FU,FLAGS,DEST_SRC,S1_SRC,S2_SRC,IMM}, MSB first
  typedef struct packed {
    logic       we;
    op_e        op;
    fu_e        fu;
    logic [3:0] flags;
    logic [1:0] dest_src;
    logic [1:0] s1_src;
    logic [3:0] s2_src;
    logic       imm;
  } ucode_s;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_BR = 1'b1
  } disp_state_e;

  function automatic logic is_noop(input fu_e fu);
    return fu == NOOP_FU;
  endfunction

endpackage

// File: rtl/ucode_fifo.sv
// Circular queue with valid/ready push, valid/yumi pop
// and a synchronous clear; storage itself is not reset.
module ucode_fifo #(
  parameter int WIDTH_P = 1,
  parameter int DEPTH_P = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [WIDTH_P-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [WIDTH_P-1:0] data_o,
  input  logic               yumi_i
);

  localparam int PW = $clog2(DEPTH_P);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH_P);

  logic [WIDTH_P-1:0] mem [DEPTH_P];
  logic [PW-1:0]      head_r;
  logic [PW-1:0]      tail_r;
  logic [CW-1:0]      count_r;
  logic               push;
  logic               pop;

  assign ready_o = count_r != FULL;
  assign v_o     = count_r != '0;
  assign data_o  = mem[head_r];
  assign push    = v_i & ready_o & ~clear_i;
  assign pop     = yumi_i & v_o & ~clear_i;

  // pointers wrap naturally since DEPTH_P is a power of two
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) tail_r <= tail_r + 1'b1;
      if (pop)  head_r <= head_r + 1'b1;
      unique case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // entry storage, written at the tail
  always_ff @(posedge clk_i) begin
    if (push) mem[tail_r] <= data_i;
  end

endmodule

// File: rtl/ucode_dispatch.sv
// Microcode dispatch: queues FE words, issues the head to
// its FU, and stalls behind a dispatched branch.
module ucode_dispatch
  import Purple_Jade_pkg::*;
#(
  parameter int DEPTH_P  = 4,
  parameter int NUM_FU_P = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     ucode_v_i,
  input  logic [UCODE_WIDTH_P-1:0] ucode_i,
  input  logic [15:0]              instr_i,
  input  logic [15:0]              pc_i,
  output logic                     ucode_ready_o,
  input  logic                     flush_i,
  input  logic [NUM_FU_P-1:0]      fu_ready_i,
  input  logic                     branch_resolved_i,
  output logic                     dispatch_v_o,
  output logic [FU_WIDTH_P-1:0]    dispatch_fu_o,
  output logic [2:0]               dispatch_op_o,
  output logic                     we_o,
  output logic [3:0]               flags_o,
  output logic [1:0]               dest_src_o,
  output logic [1:0]               s1_src_o,
  output logic [3:0]               s2_src_o,
  output logic                     imm_o,
  output logic [15:0]              instr_o,
  output logic [15:0]              pc_o
);

  logic [ENTRY_WIDTH_P-1:0] push_data;
  logic [ENTRY_WIDTH_P-1:0] head_data;
  logic                     push_v;
  logic                     head_v;
  logic                     pop;
  logic                     run;
  logic                     fu_ok;
  ucode_s                   head_uc;
  logic [15:0]              head_instr;
  logic [15:0]              head_pc;
  disp_state_e              state_r;
  disp_state_e              state_n;

  assign push_data = {ucode_i, instr_i, pc_i};
  assign push_v    = ucode_v_i & ~flush_i;

  ucode_fifo #(
    .WIDTH_P (ENTRY_WIDTH_P),
    .DEPTH_P (DEPTH_P)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush_i),
    .v_i     (push_v),
    .data_i  (push_data),
    .ready_o (ucode_ready_o),
    .v_o     (head_v),
    .data_o  (head_data),
    .yumi_i  (pop)
  );

  assign {head_uc, head_instr, head_pc} = head_data;

  assign fu_ok = fu_ready_i[head_uc.fu];
  assign run   = head_v & (state_r == RUN) & ~flush_i;

  assign dispatch_v_o = run & ~is_noop(head_uc.fu) & fu_ok;
  assign pop          = dispatch_v_o | (run & is_noop(head_uc.fu));

  assign dispatch_fu_o = head_uc.fu;
  assign dispatch_op_o = head_uc.op;
  assign we_o          = head_uc.we;
  assign flags_o       = head_uc.flags;
  assign dest_src_o    = head_uc.dest_src;
  assign s1_src_o      = head_uc.s1_src;
  assign s2_src_o      = head_uc.s2_src;
  assign imm_o         = head_uc.imm;
  assign instr_o       = head_instr;
  assign pc_o          = head_pc;

  // dispatch state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= RUN;
    else         state_r <= state_n;
  end

  // branch wait: enter after a branch issues, leave on resolve
  always_comb begin
    state_n = state_r;
    if (flush_i) begin
      state_n = RUN;
    end else begin
      unique case (state_r)
        RUN: begin
          if (dispatch_v_o && head_uc.fu == BRANCH_FU)
            state_n = WAIT_BR;
        end
        WAIT_BR: begin
          if (branch_resolved_i) state_n = RUN;
        end
        default: state_n = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_dispatch.sv
// Directed and scoreboarded checks for ucode_dispatch.
// Inputs driven 1 time unit after posedge, outputs sampled before next edge.
module tb_ucode_dispatch;
  import Purple_Jade_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset_i = 1'b1;
  logic                     ucode_v_i = 1'b0;
  logic [UCODE_WIDTH_P-1:0] ucode_i = '0;
  logic [15:0]              instr_i = '0;
  logic [15:0]              pc_i = '0;
  logic                     ucode_ready_o;
  logic                     flush_i = 1'b0;
  logic [7:0]               fu_ready_i = '0;
  logic                     branch_resolved_i = 1'b0;
  logic                     dispatch_v_o;
  logic [FU_WIDTH_P-1:0]    dispatch_fu_o;
  logic [2:0]               dispatch_op_o;
  logic                     we_o;
  logic [3:0]               flags_o;
  logic [1:0]               dest_src_o;
  logic [1:0]               s1_src_o;
  logic [3:0]               s2_src_o;
  logic                     imm_o;
  logic [15:0]              instr_o;
  logic [15:0]              pc_o;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  ucode_dispatch #(
    .DEPTH_P  (4),
    .NUM_FU_P (8)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .ucode_v_i         (ucode_v_i),
    .ucode_i           (ucode_i),
    .instr_i           (instr_i),
    .pc_i              (pc_i),
    .ucode_ready_o     (ucode_ready_o),
    .flush_i           (flush_i),
    .fu_ready_i        (fu_ready_i),
    .branch_resolved_i (branch_resolved_i),
    .dispatch_v_o      (dispatch_v_o),
    .dispatch_fu_o     (dispatch_fu_o),
    .dispatch_op_o     (dispatch_op_o),
    .we_o              (we_o),
    .flags_o           (flags_o),
    .dest_src_o        (dest_src_o),
    .s1_src_o          (s1_src_o),
    .s2_src_o          (s2_src_o),
    .imm_o             (imm_o),
    .instr_o           (instr_o),
    .pc_o              (pc_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [UCODE_WIDTH_P-1:0] mk(
      input fu_e fu, input op_e op);
    ucode_s u;
    u          = '0;
    u.we       = 1'b1;
    u.op       = op;
    u.fu       = fu;
    u.flags    = 4'hA;
    u.dest_src = 2'b01;
    u.s1_src   = 2'b10;
    u.s2_src   = 4'h9;
    u.imm      = 1'b1;
    return u;
  endfunction

  task automatic drive(input fu_e fu, input logic [15:0] pc);
    ucode_v_i = 1'b1;
    ucode_i   = mk(fu, OP_ADD);
    pc_i      = pc;
    instr_i   = pc ^ 16'hA5A5;
  endtask

  logic [15:0] mq_pc[$];
  logic [15:0] mq_in[$];
  fu_e         mq_fu[$];
  disp_state_e mst;
  logic [15:0] seq;

  initial begin
    // reset
    step();
    chk("rst_ready", ucode_ready_o, 1);
    chk("rst_dv", dispatch_v_o, 0);
    step();
    reset_i = 1'b0;
    #1;
    chk("post_rst_ready", ucode_ready_o, 1);
    chk("post_rst_dv", dispatch_v_o, 0);

    // single ALU ADD
    fu_ready_i = 8'hFF;
    drive(ALU_FU, 16'h0010);
    step();
    ucode_v_i = 1'b0;
    #1;
    chk("alu_dv", dispatch_v_o, 1);
    chk("alu_fu", dispatch_fu_o, ALU_FU);
    chk("alu_op", dispatch_op_o, OP_ADD);
    chk("alu_pc", pc_o, 16'h0010);
    chk("alu_instr", instr_o, 16'h0010 ^ 16'hA5A5);
    chk("alu_we", we_o, 1);
    chk("alu_flags", flags_o, 4'hA);
    chk("alu_dest", dest_src_o, 2'b01);
    chk("alu_s1", s1_src_o, 2'b10);
    chk("alu_s2", s2_src_o, 4'h9);
    chk("alu_imm", imm_o, 1);
    step();
    chk("alu_empty_dv", dispatch_v_o, 0);
    chk("alu_empty_rdy", ucode_ready_o, 1);

    // fill to full with FUs stalled
    fu_ready_i = 8'h00;
    for (int k = 0; k < 4; k++) begin
      drive(MEM_FU, 16'h0020 + 16'(k));
      step();
    end
    chk("full_rdy", ucode_ready_o, 0);
    drive(MEM_FU, 16'h0024);
    step();
    ucode_v_i = 1'b0;
    #1;
    chk("stall_rdy", ucode_ready_o, 0);
    chk("stall_dv", dispatch_v_o, 0);
    chk("stall_pc", pc_o, 16'h0020);
    step();
    chk("stall_hold_pc", pc_o, 16'h0020);
    fu_ready_i = 8'hFF;
    #1;
    chk("drain0_dv", dispatch_v_o, 1);
    chk("drain0_pc", pc_o, 16'h0020);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("drain_dv", dispatch_v_o, 1);
      chk("drain_pc", pc_o, 16'h0020 + 16'(k));
      chk("drain_rdy", ucode_ready_o, 1);
    end
    step();
    chk("drain_end_dv", dispatch_v_o, 0);

    // NOOP popped silently, then MUL
    drive(NOOP_FU, 16'h0030);
    step();
    drive(MUL_FU, 16'h0031);
    #1;
    chk("noop_dv", dispatch_v_o, 0);
    step();
    ucode_v_i = 1'b0;
    #1;
    chk("mul_dv", dispatch_v_o, 1);
    chk("mul_fu", dispatch_fu_o, MUL_FU);
    chk("mul_pc", pc_o, 16'h0031);
    step();
    chk("mul_end_dv", dispatch_v_o, 0);

    // branch wait
    drive(BRANCH_FU, 16'h0040);
    step();
    drive(ALU_FU, 16'h0041);
    #1;
    chk("bcc_dv", dispatch_v_o, 1);
    chk("bcc_fu", dispatch_fu_o, BRANCH_FU);
    chk("bcc_pc", pc_o, 16'h0040);
    step();
    ucode_v_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("wait_dv", dispatch_v_o, 0);
      chk("wait_pc", pc_o, 16'h0041);
      step();
    end
    branch_resolved_i = 1'b1;
    #1;
    chk("resolve_dv", dispatch_v_o, 0);
    step();
    branch_resolved_i = 1'b0;
    #1;
    chk("post_br_dv", dispatch_v_o, 1);
    chk("post_br_pc", pc_o, 16'h0041);
    step();
    chk("post_br_end", dispatch_v_o, 0);

    // flush during WAIT_BR with push and resolve
    drive(BRANCH_FU, 16'h0050);
    step();
    drive(ALU_FU, 16'h0051);
    #1;
    chk("fl_bcc_dv", dispatch_v_o, 1);
    step();
    drive(ALU_FU, 16'h0052);
    step();
    drive(ALU_FU, 16'h0053);
    step();
    ucode_v_i = 1'b0;
    #1;
    chk("fl_wait_dv", dispatch_v_o, 0);
    chk("fl_wait_rdy", ucode_ready_o, 1);
    flush_i = 1'b1;
    branch_resolved_i = 1'b1;
    drive(ALU_FU, 16'h0054);
    #1;
    chk("fl_cyc_dv", dispatch_v_o, 0);
    step();
    flush_i = 1'b0;
    branch_resolved_i = 1'b0;
    ucode_v_i = 1'b0;
    #1;
    chk("fl_after_dv", dispatch_v_o, 0);
    chk("fl_after_rdy", ucode_ready_o, 1);
    drive(ALU_FU, 16'h0060);
    step();
    ucode_v_i = 1'b0;
    #1;
    chk("fl_run_dv", dispatch_v_o, 1);
    chk("fl_run_pc", pc_o, 16'h0060);
    step();

    // reset in WAIT_BR
    drive(BRANCH_FU, 16'h0070);
    step();
    drive(ALU_FU, 16'h0071);
    step();
    ucode_v_i = 1'b0;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    chk("rst_wb_rdy", ucode_ready_o, 1);
    chk("rst_wb_dv", dispatch_v_o, 0);
    drive(ALU_FU, 16'h0072);
    step();
    ucode_v_i = 1'b0;
    #1;
    chk("rst_wb_run_dv", dispatch_v_o, 1);
    chk("rst_wb_run_pc", pc_o, 16'h0072);
    step();

    // random traffic against a queue model
    mst = RUN;
    seq = 16'h1000;
    for (int i = 0; i < 1000; i++) begin
      logic ev;
      logic ep;
      logic full;
      ucode_s u;
      fu_e hf;
      flush_i = ($urandom_range(0, 39) == 0);
      branch_resolved_i = ($urandom_range(0, 3) == 0);
      fu_ready_i = 8'($urandom);
      ucode_v_i = 1'($urandom);
      u = '0;
      u.fu = fu_e'(3'($urandom_range(0, 6)));
      u.op = op_e'(3'($urandom));
      ucode_i = u;
      pc_i = seq;
      instr_i = 16'($urandom);
      #1;
      hf = (mq_fu.size() > 0) ? mq_fu[0] : NOOP_FU;
      ev = (mq_fu.size() > 0) && (mst == RUN) && !flush_i &&
           (hf != NOOP_FU) && fu_ready_i[hf];
      chk("rnd_dv", dispatch_v_o, ev);
      chk("rnd_rdy", ucode_ready_o, mq_fu.size() != 4);
      if (ev) begin
        chk("rnd_pc", pc_o, mq_pc[0]);
        chk("rnd_in", instr_o, mq_in[0]);
        chk("rnd_fu", dispatch_fu_o, hf);
      end
      if (flush_i) begin
        mq_pc.delete();
        mq_in.delete();
        mq_fu.delete();
        mst = RUN;
      end else begin
        full = mq_fu.size() == 4;
        ep = (mq_fu.size() > 0) && (mst == RUN) &&
             ((hf == NOOP_FU) || fu_ready_i[hf]);
        if (ev && hf == BRANCH_FU) mst = WAIT_BR;
        else if (mst == WAIT_BR && branch_resolved_i) mst = RUN;
        if (ep) begin
          void'(mq_pc.pop_front());
          void'(mq_in.pop_front());
          void'(mq_fu.pop_front());
        end
        if (ucode_v_i && !full) begin
          mq_pc.push_back(pc_i);
          mq_in.push_back(instr_i);
          mq_fu.push_back(u.fu);
          seq = seq + 16'd1;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
